// File: rtl/bitstream_pkg.sv
// Shared types and constants for the bitstream arbiter: source indices,
// arbiter state encoding, beat record and the value-masking helper.
package bitstream_pkg;

    localparam int NUM_SRC_DEFAULT = 3;
    localparam int SRC_FRAME_HDR   = 0;
    localparam int SRC_PIC_HDR     = 1;
    localparam int SRC_SLICE       = 2;

    localparam logic [63:0] MAX_SIZE = 64'd64;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic [63:0] val;
        logic [63:0] size;
        logic        flush;
        logic        last;
    } beat_t;

    // Clear every value bit at or above the beat size.
    function automatic logic [63:0] mask_val(input logic [63:0] v, input logic [63:0] size);
        logic [63:0] m;
        if (size >= MAX_SIZE) begin
            m = {64{1'b1}};
        end else begin
            m = (64'd1 << size[5:0]) - 64'd1;
        end
        return v & m;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin selector: one-hot pick of the first asserted
// request at or after the pointer, wrapping at N.
module rr_picker #(
    parameter int N     = 3,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     pick_o
);

    logic [2*N-1:0] dbl_s;
    logic [N-1:0]   rot_s;
    logic [N-1:0]   hot_s;
    logic [2*N-1:0] back_s;
    logic           found_s;

    // Rotate so the pointer is bit 0, take the lowest set bit, rotate back.
    always_comb begin
        dbl_s   = {req_i, req_i} >> ptr_i;
        rot_s   = dbl_s[N-1:0];
        hot_s   = '0;
        found_s = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found_s && rot_s[k]) begin
                hot_s[k] = 1'b1;
                found_s  = 1'b1;
            end else begin
                hot_s[k] = hot_s[k];
            end
        end
        back_s = {{N{1'b0}}, hot_s} << ptr_i;
        pick_o = back_s[N-1:0] | back_s[2*N-1:N];
    end

endmodule

// File: rtl/bitstream_arbiter.sv
// Locks one header/slice source at a time onto the bit packer, forwards its
// beats through one output register and tracks the flush-aligned bit count.
module bitstream_arbiter
    import bitstream_pkg::*;
#(
    parameter int NUM_SRC = NUM_SRC_DEFAULT,
    parameter int CNT_W   = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_SRC-1:0]       req_valid,
    input  logic [NUM_SRC-1:0][63:0] req_val,
    input  logic [NUM_SRC-1:0][63:0] req_size,
    input  logic [NUM_SRC-1:0]       req_flush,
    input  logic [NUM_SRC-1:0]       req_last,
    output logic [NUM_SRC-1:0]       req_ready,
    input  logic                     out_ready,
    output logic                     output_enable,
    output logic [63:0]              val,
    output logic [63:0]              size_of_bit,
    output logic                     flush_bit,
    output logic [CNT_W-1:0]         bit_count,
    output logic [NUM_SRC-1:0]       grant,
    output logic                     size_err
);

    localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    arb_state_e         state_q, state_d;
    logic [NUM_SRC-1:0] grant_q, grant_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               oe_q, oe_d;
    logic [63:0]        val_q, val_d;
    logic [63:0]        size_q, size_d;
    logic               flush_q, flush_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;

    logic [NUM_SRC-1:0] pick_s;
    logic [NUM_SRC-1:0] elig_s;
    logic               accept_s;
    logic               size_ok_s;
    beat_t              sel_s;
    logic [PTR_W-1:0]   sel_idx_s;
    logic [PTR_W-1:0]   next_ptr_s;
    logic [CNT_W-1:0]   sum_s;

    rr_picker #(
        .N     (NUM_SRC),
        .PTR_W (PTR_W)
    ) u_rr_picker (
        .req_i  (req_valid),
        .ptr_i  (rr_ptr_q),
        .pick_o (pick_s)
    );

    // Eligibility, handshake and the beat of the eligible source.
    always_comb begin
        elig_s    = (state_q == ST_LOCKED) ? grant_q : pick_s;
        req_ready = (!reset && (!oe_q || out_ready)) ? elig_s : '0;
        accept_s  = |(req_valid & req_ready);
        sel_s     = '0;
        sel_idx_s = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (elig_s[i]) begin
                sel_s.val   = req_val[i];
                sel_s.size  = req_size[i];
                sel_s.flush = req_flush[i];
                sel_s.last  = req_last[i];
                sel_idx_s   = PTR_W'(i);
            end else begin
                sel_idx_s   = sel_idx_s;
            end
        end
        size_ok_s  = (sel_s.size <= MAX_SIZE);
        next_ptr_s = (sel_idx_s == PTR_W'(NUM_SRC - 1)) ? '0 : sel_idx_s + PTR_W'(1);
        sum_s      = cnt_q + CNT_W'(sel_s.size);
    end

    // Lock FSM: a last beat releases the lock and advances the pointer.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s && !sel_s.last) begin
                    state_d = ST_LOCKED;
                    grant_d = elig_s;
                end else if (accept_s) begin
                    rr_ptr_d = next_ptr_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                if (accept_s && sel_s.last) begin
                    state_d  = ST_IDLE;
                    grant_d  = '0;
                    rr_ptr_d = next_ptr_s;
                end else begin
                    state_d = ST_LOCKED;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Output register, bit counter and oversize flag next-state.
    always_comb begin
        oe_d    = oe_q;
        val_d   = val_q;
        size_d  = size_q;
        flush_d = flush_q;
        cnt_d   = cnt_q;
        err_d   = err_q | (accept_s && !size_ok_s);
        if (accept_s && size_ok_s) begin
            oe_d    = 1'b1;
            val_d   = mask_val(sel_s.val, sel_s.size);
            size_d  = sel_s.size;
            flush_d = sel_s.flush;
            cnt_d   = sel_s.flush ? ((sum_s + CNT_W'(7)) & ~CNT_W'(7)) : sum_s;
        end else if (out_ready) begin
            oe_d = 1'b0;
        end else begin
            oe_d = oe_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            oe_q     <= 1'b0;
            val_q    <= 64'd0;
            size_q   <= 64'd0;
            flush_q  <= 1'b0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            oe_q     <= oe_d;
            val_q    <= val_d;
            size_q   <= size_d;
            flush_q  <= flush_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    assign output_enable = oe_q;
    assign val           = val_q;
    assign size_of_bit   = size_q;
    assign flush_bit     = flush_q;
    assign bit_count     = cnt_q;
    assign grant         = grant_q;
    assign size_err      = err_q;

endmodule

// File: doc/bitstream_arbiter.md
BITSTREAM_ARBITER -- requirements
Module: bitstream_arbiter

Interface
REQ-001 Parameter NUM_SRC, default 3: requester count (0 frame header, 1 picture/slice header, 2 slice data).
REQ-002 Parameter CNT_W, default 32: bit-counter width.
REQ-003 clock  input  1  sole clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  NUM_SRC  per-source beat valid.
REQ-006 req_val  input  NUM_SRC x 64  per-source value bits, right-aligned.
REQ-007 req_size  input  NUM_SRC x 64  per-source size_of_bit.
REQ-008 req_flush  input  NUM_SRC  per-source flush_bit.
REQ-009 req_last  input  NUM_SRC  last beat of the source's burst.
REQ-010 req_ready  output  NUM_SRC  per-source beat accepted this cycle.
REQ-011 out_ready  input  1  downstream packer can take a beat.
REQ-012 output_enable  output  1  val/size_of_bit/flush_bit valid.
REQ-013 val, size_of_bit  output  64 each  beat to packer.
REQ-014 flush_bit  output  1  byte-align request to packer.
REQ-015 bit_count  output  CNT_W  total bits emitted since reset, flush-aligned.
REQ-016 grant  output  NUM_SRC  one-hot owner, all-zero when idle.
REQ-017 size_err  output  1  sticky: beat with size_of_bit > 64 seen.

Function
REQ-018 FSM states IDLE and LOCKED; reset state IDLE.
REQ-019 IDLE: if any req_valid, grant the first valid source at or after rr_ptr (wrapping at NUM_SRC), accept its beat in the same cycle, enter LOCKED unless that beat has req_last.
REQ-020 LOCKED: only the granted source can be accepted; other sources get req_ready=0 regardless of req_valid.
REQ-021 A beat is accepted when req_valid[g] && req_ready[g]; req_ready[g] = grant-eligible && (output register empty || out_ready).
REQ-022 An accepted beat with req_last=1 returns the FSM to IDLE and sets rr_ptr = (g+1) mod NUM_SRC in the same edge.
REQ-023 Output is a single register stage: an accepted beat appears on val/size_of_bit/flush_bit with output_enable=1 exactly 1 cycle later.
REQ-024 Output holds stable while output_enable=1 && out_ready=0; it updates only when out_ready=1 or the register is empty.
REQ-025 output_enable deasserts the cycle after its beat is consumed, unless a new beat was accepted on the same edge.
REQ-026 bit_count updates on acceptance: bit_count += size; if flush, then round up to the next multiple of 8; arithmetic is modulo 2^CNT_W.
REQ-027 size_of_bit = 0 is legal (pure flush or no-op) and is forwarded unchanged.
REQ-028 size > 64: beat is accepted (req_ready honoured), dropped (not output, count unchanged), and size_err is set; req_last on it still ends the lock.
REQ-029 Source deasserting req_valid mid-burst: lock is held and no other source is served until that source's last beat.
REQ-030 val bits above size_of_bit are forced to zero on the output.

Reset
REQ-031 When reset=1 at an edge: FSM=IDLE, rr_ptr=0, grant=0, output_enable=0, val=0, size_of_bit=0, flush_bit=0, bit_count=0, size_err=0, req_ready=0.
REQ-032 Reset mid-burst abandons the lock and any pending output beat with no partial emission afterward.

Structure
REQ-033 Package bitstream_pkg holds NUM_SRC default, source index constants (SRC_FRAME_HDR=0, SRC_PIC_HDR=1, SRC_SLICE=2), the state enum, and the beat struct {val, size, flush, last}.
REQ-034 Round-robin selection is sub-module rr_picker: inputs request vector and pointer; output one-hot pick; purely combinational.

Verification
REQ-035 Source 0 only sends 3 beats (0x0/32, 0x69637066/32, 0x94/16, last on the third), out_ready=1 -> outputs at cycles +1,+2,+3 in order; bit_count=80; grant returns to 0.
REQ-036 All 3 sources valid, each sending 2-beat bursts -> service order 0,1,2, then 0 again; no interleaving inside a burst.
REQ-037 out_ready=0 for 4 cycles with a beat pending -> output held constant, req_ready=0, no beat lost or duplicated after release.
REQ-038 Beats of size 3 then size 0 with flush -> bit_count goes 3 then 8; output shows size 0, flush=1.
REQ-039 Beat of size 65 with val=all-ones -> no output, size_err=1 and stays set, bit_count unchanged.
REQ-040 Reset asserted during a LOCKED burst of source 2 -> next cycle all outputs zero; after release, source 0 is granted first.
